// File: rtl/sbox_tbox_arbiter.sv
// rtl/sbox_tbox_arbiter.sv - two-requester arbiter in front of a shared sbox/tbox lookup unit
//
// Shares one combinational column lookup unit between the key-schedule (ks_*)
// and round-datapath (rd_*) requesters. A single registered output stage holds
// the lookup result together with the identity of the requester that owns it.
//
// Parameters
//   WORD_W   column word width (4 bytes)
//   ENTRY_W  width of one combined sbox/tbox lookup entry
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   ks_req_valid/word/ready      key-schedule request handshake
//   ks_resp_valid/ready          key-schedule response handshake
//   rd_req_valid/word/ready      round-datapath request handshake
//   rd_resp_valid/ready          round-datapath response handshake
//   lu_word                      column word presented to the lookup unit
//   lu_words                     four lookup entries, entry 0 in the MSBs
//   resp_words                   registered lookup result shared by both requesters
//
// Configuration
//   SBOX_ARB_RR_EN  defined: round-robin grant; undefined: fixed priority KS over RD

module sbox_tbox_arbiter #(
    parameter int WORD_W  = 32,
    parameter int ENTRY_W = 80
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 ks_req_valid,
    input  logic [WORD_W-1:0]    ks_req_word,
    output logic                 ks_req_ready,
    output logic                 ks_resp_valid,
    input  logic                 ks_resp_ready,

    input  logic                 rd_req_valid,
    input  logic [WORD_W-1:0]    rd_req_word,
    output logic                 rd_req_ready,
    output logic                 rd_resp_valid,
    input  logic                 rd_resp_ready,

    output logic [WORD_W-1:0]    lu_word,
    input  logic [4*ENTRY_W-1:0] lu_words,
    output logic [4*ENTRY_W-1:0] resp_words
);

    localparam logic OWNER_KS = 1'b0;
    localparam logic OWNER_RD = 1'b1;

    // Output stage state
    logic                 out_valid_q,  out_valid_d;
    logic                 owner_q,      owner_d;
    logic [4*ENTRY_W-1:0] resp_words_q, resp_words_d;

    // Last word presented to the lookup unit, replayed when nobody is granted
    logic [WORD_W-1:0]    lu_word_q,    lu_word_d;

`ifdef SBOX_ARB_RR_EN
    // Requester that wins the next simultaneous request
    logic                 rr_ptr_q,     rr_ptr_d;
`endif

    logic owner_ready;
    logic stage_free;
    logic any_req;
    logic pick_rd;
    logic accept;
    logic ks_accept;
    logic rd_accept;

    // Grant evaluation
    always_comb begin
        owner_ready = (owner_q == OWNER_RD) ? rd_resp_ready : ks_resp_ready;
        // Draining the held response frees the stage in the same cycle, so a
        // new request can be accepted without a bubble.
        stage_free  = !out_valid_q || owner_ready;
        any_req     = ks_req_valid || rd_req_valid;
`ifdef SBOX_ARB_RR_EN
        pick_rd     = rd_req_valid && (!ks_req_valid || (rr_ptr_q == OWNER_RD));
`else
        pick_rd     = rd_req_valid && !ks_req_valid;
`endif
        // rst gates the accept so no ready is raised while reset is held,
        // even though the handshake inputs may already be active.
        accept      = !rst && stage_free && any_req;
        ks_accept   = accept && !pick_rd;
        rd_accept   = accept &&  pick_rd;
    end

    // Lookup unit drive
    always_comb begin
        if (rst) begin
            lu_word = '0;
        end else if (ks_accept) begin
            lu_word = ks_req_word;
        end else if (rd_accept) begin
            lu_word = rd_req_word;
        end else begin
            lu_word = lu_word_q;
        end
    end

    // Next-state logic
    always_comb begin
        out_valid_d  = out_valid_q;
        owner_d      = owner_q;
        resp_words_d = resp_words_q;
        lu_word_d    = lu_word;
`ifdef SBOX_ARB_RR_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        if (accept) begin
            out_valid_d  = 1'b1;
            owner_d      = pick_rd ? OWNER_RD : OWNER_KS;
            resp_words_d = lu_words;
`ifdef SBOX_ARB_RR_EN
            // The grantee drops to lower priority for the next contest.
            rr_ptr_d     = pick_rd ? OWNER_KS : OWNER_RD;
`endif
        end else if (out_valid_q && owner_ready) begin
            // Drained with nothing behind it; data is kept, only valid drops.
            out_valid_d  = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            owner_q      <= OWNER_KS;
            resp_words_q <= '0;
            lu_word_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            owner_q      <= owner_d;
            resp_words_q <= resp_words_d;
            lu_word_q    <= lu_word_d;
        end
    end

`ifdef SBOX_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= OWNER_KS;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Outputs
    always_comb begin
        ks_req_ready  = ks_accept;
        rd_req_ready  = rd_accept;
        ks_resp_valid = out_valid_q && (owner_q == OWNER_KS);
        rd_resp_valid = out_valid_q && (owner_q == OWNER_RD);
        resp_words    = resp_words_q;
    end

endmodule

// File: tb/tb_sbox_tbox_arbiter.sv
// tb/tb_sbox_tbox_arbiter.sv - directed self-checking bench for sbox_tbox_arbiter
module tb_sbox_tbox_arbiter;

    localparam int WORD_W  = 32;
    localparam int ENTRY_W = 80;
    localparam int LW      = 4 * ENTRY_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ks_req_valid = 1'b0;
    logic [WORD_W-1:0] ks_req_word  = '0;
    logic              ks_req_ready;
    logic              ks_resp_valid;
    logic              ks_resp_ready = 1'b0;
    logic              rd_req_valid = 1'b0;
    logic [WORD_W-1:0] rd_req_word  = '0;
    logic              rd_req_ready;
    logic              rd_resp_valid;
    logic              rd_resp_ready = 1'b0;
    logic [WORD_W-1:0] lu_word;
    logic [LW-1:0]     lu_words;
    logic [LW-1:0]     resp_words;

    int checks = 0;
    int errors = 0;

    sbox_tbox_arbiter #(.WORD_W(WORD_W), .ENTRY_W(ENTRY_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .ks_req_valid  (ks_req_valid),
        .ks_req_word   (ks_req_word),
        .ks_req_ready  (ks_req_ready),
        .ks_resp_valid (ks_resp_valid),
        .ks_resp_ready (ks_resp_ready),
        .rd_req_valid  (rd_req_valid),
        .rd_req_word   (rd_req_word),
        .rd_req_ready  (rd_req_ready),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_ready (rd_resp_ready),
        .lu_word       (lu_word),
        .lu_words      (lu_words),
        .resp_words    (resp_words)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] e;
        r = 8'h01;
        e = 8'hfe;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (e[i]) r = gmul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = ginv(b);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] b);
        return ginv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
    endfunction

    // Entry = {S, Te0 word, S^-1, Td0 word}, table words rotated right by i bytes
    function automatic logic [ENTRY_W-1:0] entry(input logic [7:0] b, input int i);
        logic [7:0]  s;
        logic [7:0]  si;
        logic [31:0] te;
        logic [31:0] td;
        logic [63:0] t;
        s  = sbox(b);
        si = isbox(b);
        te = {gmul(s, 8'h02), s, s, gmul(s, 8'h03)};
        td = {gmul(si, 8'h0e), gmul(si, 8'h09), gmul(si, 8'h0d), gmul(si, 8'h0b)};
        t  = {te, te} >> (8 * i);
        te = t[31:0];
        t  = {td, td} >> (8 * i);
        td = t[31:0];
        return {s, te, si, td};
    endfunction

    function automatic logic [LW-1:0] lookup4(input logic [WORD_W-1:0] w);
        logic [LW-1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[LW-1-i*ENTRY_W -: ENTRY_W] = entry(w[WORD_W-1-8*i -: 8], i);
        end
        return r;
    endfunction

    always_comb lu_words = lookup4(lu_word);

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin : main
        logic [LW-1:0]     held;
        logic [WORD_W-1:0] w;
        int                ks_cnt;
        int                rd_cnt;
        int                sent;
        int                got;
        int                cyc;

        // Reset state, with requests already pending
        ks_req_valid = 1'b1;
        rd_req_valid = 1'b1;
        ks_req_word  = 32'hdeadbeef;
        rd_req_word  = 32'hcafef00d;
        tick();
        @(negedge clk);
        chk("rst_ks_req_ready",  ks_req_ready,  1'b0);
        chk("rst_rd_req_ready",  rd_req_ready,  1'b0);
        chk("rst_ks_resp_valid", ks_resp_valid, 1'b0);
        chk("rst_rd_resp_valid", rd_resp_valid, 1'b0);
        chk("rst_lu_word",       lu_word,       '0);
        chk("rst_resp_words",    resp_words,    '0);
        ks_req_valid = 1'b0;
        rd_req_valid = 1'b0;
        tick();
        rst = 1'b0;

        // Single KS request of word 0, 1-cycle latency
        ks_req_valid = 1'b1;
        ks_req_word  = 32'h00000000;
        @(negedge clk);
        chk("ks0_req_ready", ks_req_ready, 1'b1);
        chk("ks0_lu_word",   lu_word,      32'h00000000);
        tick();
        ks_req_valid  = 1'b0;
        ks_resp_ready = 1'b0;
        rd_resp_ready = 1'b1;
        @(negedge clk);
        chk("ks0_resp_valid", ks_resp_valid, 1'b1);
        chk("ks0_rd_resp_valid", rd_resp_valid, 1'b0);
        chk("ks0_entry0", resp_words[LW-1 -: ENTRY_W], 80'h63c66363a55251f4a750);
        chk("ks0_resp_all", resp_words, lookup4(32'h00000000));
        // Non-owner ready pulse is ignored
        tick();
        rd_resp_ready = 1'b0;
        @(negedge clk);
        chk("nonowner_ks_resp_valid", ks_resp_valid, 1'b1);
        chk("nonowner_resp_stable", resp_words, lookup4(32'h00000000));
        tick();
        ks_resp_ready = 1'b1;
        @(negedge clk);
        chk("ks0_deliver_valid", ks_resp_valid, 1'b1);
        tick();
        ks_resp_ready = 1'b0;
        @(negedge clk);
        chk("ks0_drained_valid", ks_resp_valid, 1'b0);
        chk("ks0_drained_hold",  resp_words, lookup4(32'h00000000));

        // Held KS response blocks both requesters, then same-cycle refill by RD
        tick();
        ks_req_valid = 1'b1;
        ks_req_word  = 32'h53535353;
        @(negedge clk);
        chk("hold_ks_req_ready", ks_req_ready, 1'b1);
        tick();
        ks_req_valid = 1'b0;
        rd_req_valid = 1'b1;
        rd_req_word  = 32'h00010203;
        held = lookup4(32'h53535353);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_ks_resp_valid", ks_resp_valid, 1'b1);
            chk("hold_ks_req_ready0", ks_req_ready, 1'b0);
            chk("hold_rd_req_ready0", rd_req_ready, 1'b0);
            chk("hold_resp_words", resp_words, held);
            chk("hold_sbox53", resp_words[LW-1 -: 8], 8'hed);
            tick();
        end
        ks_resp_ready = 1'b1;
        @(negedge clk);
        chk("refill_rd_req_ready", rd_req_ready, 1'b1);
        chk("refill_lu_word", lu_word, 32'h00010203);
        tick();
        rd_req_valid  = 1'b0;
        ks_resp_ready = 1'b0;
        rd_resp_ready = 1'b1;
        @(negedge clk);
        chk("refill_rd_resp_valid", rd_resp_valid, 1'b1);
        chk("refill_ks_resp_valid", ks_resp_valid, 1'b0);
        chk("refill_resp_words", resp_words, lookup4(32'h00010203));
        tick();
        rd_resp_ready = 1'b0;
        @(negedge clk);
        chk("refill_drained", rd_resp_valid, 1'b0);

        // Contention: both requesters valid for 8 cycles
        do_reset();
        ks_req_valid  = 1'b1;
        rd_req_valid  = 1'b1;
        ks_req_word   = 32'h11111111;
        rd_req_word   = 32'h22222222;
        ks_resp_ready = 1'b1;
        rd_resp_ready = 1'b1;
        ks_cnt = 0;
        rd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ks_req_ready) ks_cnt++;
            if (rd_req_ready) rd_cnt++;
`ifdef SBOX_ARB_RR_EN
            chk("rr_alt_ks", ks_req_ready, (i % 2) == 0);
`endif
            tick();
        end
        ks_req_valid = 1'b0;
        rd_req_valid = 1'b0;
`ifdef SBOX_ARB_RR_EN
        chk("grant_ks_count", ks_cnt, 4);
        chk("grant_rd_count", rd_cnt, 4);
`else
        chk("grant_ks_count", ks_cnt, 8);
        chk("grant_rd_count", rd_cnt, 0);
`endif
        tick();
        ks_resp_ready = 1'b0;
        rd_resp_ready = 1'b0;

        // Asynchronous reset while a response is held
        ks_req_valid = 1'b1;
        ks_req_word  = 32'h0f0f0f0f;
        tick();
        ks_req_valid = 1'b0;
        #1;
        chk("async_pre_valid", ks_resp_valid, 1'b1);
        #1;
        rst = 1'b1;
        rd_req_valid = 1'b1;
        #1;
        chk("async_ks_resp_valid", ks_resp_valid, 1'b0);
        chk("async_resp_words", resp_words, '0);
        chk("async_lu_word", lu_word, '0);
        chk("async_rd_req_ready", rd_req_ready, 1'b0);
        rd_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ks_resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("postrst_ks_resp_valid", ks_resp_valid, 1'b0);
            chk("postrst_rd_resp_valid", rd_resp_valid, 1'b0);
        end
        ks_resp_ready = 1'b0;

        // Stream 256 RD words with random backpressure
        tick();
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 256 && cyc < 4000) begin
            rd_req_valid  = (sent < 256);
            rd_req_word   = {4{sent[7:0]}};
            rd_resp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rd_resp_valid && rd_resp_ready) begin
                w = {4{got[7:0]}};
                chk("stream_resp", resp_words, lookup4(w));
                got++;
            end
            if (ks_resp_valid) begin
                chk("stream_no_ks_resp", ks_resp_valid, 1'b0);
            end
            if (rd_req_ready) sent++;
            tick();
            cyc++;
        end
        rd_req_valid  = 1'b0;
        rd_resp_ready = 1'b1;
        chk("stream_got_all", got, 256);
        chk("stream_sent_all", sent, 256);
        @(negedge clk);
        chk("stream_no_extra", rd_resp_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
